// File: rtl/adld_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adld_pkg
// Brief    : Shared state encodings and default width for the add/subtract blocks
// Revision : 1.0
// ============================================================================
package adld_pkg;

    localparam int unsigned c_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_if
// Brief    : Operand/result bundle with start/done handshake for serial_subtractor
// Revision : 1.0
// ============================================================================
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = adld_pkg::c_DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] D;
    logic             Bo;
    logic             V;
    logic             busy;
    logic             done;

    modport master (
        output start, A, B,
        input  D, Bo, V, busy, done
    );

    modport slave (
        input  start, A, B,
        output D, Bo, V, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : full_subtractor
// Brief    : Single-bit combinational full subtractor cell (X - Y - Bi)
// Revision : 1.0
// ============================================================================
module full_subtractor (
    input  wire logic X,
    input  wire logic Y,
    input  wire logic Bi,
    output wire logic D,
    output wire logic Bo
);
    logic w_xy;

    assign w_xy = X ^ Y;
    assign D    = w_xy ^ Bi;
    assign Bo   = (~X & Y) | (~w_xy & Bi);
endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial two's-complement subtractor D = A - B, LSB first
// Revision : 1.0
// ============================================================================
module serial_subtractor
    import adld_pkg::*;
#(
    parameter int unsigned WIDTH = c_DEFAULT_WIDTH
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    serial_subtractor_if.slave bus
);
    localparam int unsigned        c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   ra_q, ra_d;
    logic [WIDTH-1:0]   rb_q, rb_d;
    logic [WIDTH-1:0]   rd_q, rd_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               br_q, br_d;
    logic               bo_q, bo_d;
    logic               v_q, v_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;

    logic               w_d;
    logic               w_bo;
    logic [WIDTH-1:0]   w_rd_shift;

    full_subtractor u_cell (
        .X  (ra_q[0]),
        .Y  (rb_q[0]),
        .Bi (br_q),
        .D  (w_d),
        .Bo (w_bo)
    );

    generate
        if (WIDTH == 1) begin : g_rd_w1
            assign w_rd_shift = w_d;
        end else begin : g_rd_wn
            assign w_rd_shift = {w_d, rd_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rd_d    = rd_q;
        dout_d  = dout_q;
        br_d    = br_q;
        bo_d    = bo_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    ra_d    = bus.A;
                    rb_d    = bus.B;
                    rd_d    = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                ra_d = ra_q >> 1;
                rb_d = rb_q >> 1;
                rd_d = w_rd_shift;
                br_d = w_bo;
                if (cnt_q == c_CNT_LAST) begin
                    // On the last bit ra_q[0]/rb_q[0] are the captured operand MSBs.
                    state_d = ST_DONE;
                    dout_d  = w_rd_shift;
                    bo_d    = w_bo;
                    v_d     = (ra_q[0] ^ rb_q[0]) & (w_d ^ ra_q[0]);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rd_q    <= '0;
            dout_q  <= '0;
            br_q    <= 1'b0;
            bo_q    <= 1'b0;
            v_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rd_q    <= rd_d;
            dout_q  <= dout_d;
            br_q    <= br_d;
            bo_q    <= bo_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.D    = dout_q;
    assign bus.Bo   = bo_q;
    assign bus.V    = v_q;
    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
endmodule
`default_nettype wire
